// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, FSM deserialiser, small FIFO and CPU read port.
// Optional even-parity bit between data and stop when UART_RX_PARITY_EN is defined.
module uart_rx #(
  parameter int CLKDIV    = 434,
  parameter int FIFO_LOG2 = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       addr,
  input  logic       re,
  output logic [7:0] rdata,
  output logic       irq
);

  localparam int DEPTH = 1 << FIFO_LOG2;
  localparam int CW    = $clog2(CLKDIV);
  localparam logic [CW-1:0] RELOAD = CW'(CLKDIV - 1);
  localparam logic [CW-1:0] HALF   = CW'(CLKDIV / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_t;

  logic          r_sync1, r_sync2;
  logic          w_rx;
  state_t        r_state, w_state_n;
  logic [CW-1:0] r_cnt, w_cnt_n;
  logic [2:0]    r_idx, w_idx_n;
  logic [7:0]    r_sr, w_sr_n;
  logic          w_push, w_ferr_set, w_perr_set;
  logic          r_ovr, r_ferr;
  logic          w_perr;

  logic [7:0]           r_mem [DEPTH];
  logic [FIFO_LOG2:0]   r_wp, r_rp, w_wp_n, w_rp_n;
  logic                 w_empty, w_full, w_pop, w_wr, w_ovr_set, w_clr;
  logic                 r_irq;

  assign w_rx = r_sync2;

`ifdef UART_RX_PARITY_EN
  logic r_pbad, w_pbad_n, r_perr;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_sr    <= '0;
`ifdef UART_RX_PARITY_EN
      r_pbad  <= 1'b0;
`endif
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_idx   <= w_idx_n;
      r_sr    <= w_sr_n;
`ifdef UART_RX_PARITY_EN
      r_pbad  <= w_pbad_n;
`endif
    end
  end

  always_comb begin
    w_state_n  = r_state;
    w_cnt_n    = r_cnt;
    w_idx_n    = r_idx;
    w_sr_n     = r_sr;
    w_push     = 1'b0;
    w_ferr_set = 1'b0;
    w_perr_set = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_pbad_n   = r_pbad;
`endif
    case (r_state)
      S_IDLE: begin
        if (!w_rx) begin
          w_state_n = S_START;
          w_cnt_n   = HALF;
        end
      end
      S_START: begin
        if (r_cnt == '0) begin
          if (!w_rx) begin
            w_state_n = S_DATA;
            w_cnt_n   = RELOAD;
            w_idx_n   = '0;
`ifdef UART_RX_PARITY_EN
            w_pbad_n  = 1'b0;
`endif
          end else begin
            w_state_n = S_IDLE;
          end
        end else begin
          w_cnt_n = r_cnt - CW'(1);
        end
      end
      S_DATA: begin
        if (r_cnt == '0) begin
          w_sr_n  = {w_rx, r_sr[7:1]};
          w_cnt_n = RELOAD;
          w_idx_n = r_idx + 3'd1;
          if (r_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            w_state_n = S_PARITY;
`else
            w_state_n = S_STOP;
`endif
          end
        end else begin
          w_cnt_n = r_cnt - CW'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (r_cnt == '0) begin
          w_cnt_n    = RELOAD;
          w_state_n  = S_STOP;
          w_perr_set = ^{r_sr, w_rx};
          w_pbad_n   = ^{r_sr, w_rx};
        end else begin
          w_cnt_n = r_cnt - CW'(1);
        end
      end
`endif
      S_STOP: begin
        if (r_cnt == '0) begin
          if (w_rx) begin
`ifdef UART_RX_PARITY_EN
            w_push = !r_pbad;
`else
            w_push = 1'b1;
`endif
            w_state_n = S_IDLE;
          end else begin
            w_ferr_set = 1'b1;
            w_state_n  = S_BREAK;
          end
        end else begin
          w_cnt_n = r_cnt - CW'(1);
        end
      end
      S_BREAK: begin
        if (w_rx) w_state_n = S_IDLE;
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  // Pop happens before push, so a push into a full FIFO with a same-cycle pop fits.
  assign w_empty   = (r_wp == r_rp);
  assign w_full    = (r_wp == {~r_rp[FIFO_LOG2], r_rp[FIFO_LOG2-1:0]});
  assign w_pop     = re && !addr && !w_empty;
  assign w_wr      = w_push && (!w_full || w_pop);
  assign w_ovr_set = w_push && w_full && !w_pop;
  assign w_clr     = re && addr;
  assign w_wp_n    = r_wp + {{FIFO_LOG2{1'b0}}, w_wr};
  assign w_rp_n    = r_rp + {{FIFO_LOG2{1'b0}}, w_pop};

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wp[FIFO_LOG2-1:0]] <= r_sr;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wp   <= '0;
      r_rp   <= '0;
      r_ovr  <= 1'b0;
      r_ferr <= 1'b0;
      r_irq  <= 1'b0;
    end else begin
      r_wp   <= w_wp_n;
      r_rp   <= w_rp_n;
      r_ovr  <= w_ovr_set  | (r_ovr  & ~w_clr);
      r_ferr <= w_ferr_set | (r_ferr & ~w_clr);
      r_irq  <= (w_wp_n != w_rp_n);
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_perr <= 1'b0;
    else       r_perr <= w_perr_set | (r_perr & ~w_clr);
  end
  assign w_perr = r_perr;
`else
  assign w_perr = 1'b0;
`endif

  always_comb begin
    if (addr) rdata = {3'b000, w_full, w_perr, r_ferr, r_ovr, !w_empty};
    else      rdata = w_empty ? '0 : r_mem[r_rp[FIFO_LOG2-1:0]];
  end

  assign irq = r_irq;

endmodule
